// File: rtl/reg_share_arbiter_if.sv
// Bundle of request/data and shared-register result signals between the
// requesters and reg_share_arbiter. The optional grant counter is present only
// when REG_ARB_STATS_EN is defined.
interface reg_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         q;
    logic                     q_valid;
    logic [IDX_W-1:0]         owner;
    logic                     busy;
`ifdef REG_ARB_STATS_EN
    logic [15:0]              grant_cnt;

    // Requester side: drives requests/data, observes the shared register.
    modport master (
        output req, wdata,
        input  gnt, q, q_valid, owner, busy, grant_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, wdata,
        output gnt, q, q_valid, owner, busy, grant_cnt
    );
`else
    // Requester side: drives requests/data, observes the shared register.
    modport master (
        output req, wdata,
        input  gnt, q, q_valid, owner, busy
    );

    // Arbiter side.
    modport slave (
        input  req, wdata,
        output gnt, q, q_valid, owner, busy
    );
`endif
endinterface

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin write arbiter in front of one shared WIDTH-bit
// register. A winning requester's data is loaded on the IDLE->GRANT edge, then
// q is held for HOLD_CYCLES cycles before the next arbitration.
// Optional feature macro: REG_ARB_STATS_EN adds a saturating 16-bit grant
// counter (bus.grant_cnt).
module reg_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_share_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // Value loaded into the hold counter on leaving GRANT; unused when HOLD_CYCLES==0.
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [7:0]       hold_cnt;
    logic [WIDTH-1:0] q_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [IDX_W-1:0] owner_r;
    logic             q_valid_r;
    logic             busy_r;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    int               idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = NUM_REQ'(1) << i;
    endfunction

    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] i);
        ptr_after = (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
    endfunction

`ifdef REG_ARB_STATS_EN
    logic [15:0] grant_cnt_r;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign bus.grant_cnt = grant_cnt_r;
`endif

    // Search for the first requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_data  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
                win_data  = bus.wdata[idx*WIDTH +: WIDTH];
            end
        end
    end

    // Arbitration FSM with registered outputs and the shared register itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            q_r       <= '0;
            gnt_r     <= '0;
            owner_r   <= '0;
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
`ifdef REG_ARB_STATS_EN
            grant_cnt_r <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        q_r       <= win_data;
                        owner_r   <= win_idx;
                        q_valid_r <= 1'b1;
                        gnt_r     <= onehot(win_idx);
                        rr_ptr    <= ptr_after(win_idx);
                        busy_r    <= 1'b1;
                        state     <= GRANT;
`ifdef REG_ARB_STATS_EN
                        grant_cnt_r <= sat_inc16(grant_cnt_r);
`endif
                    end
                end
                GRANT: begin
                    gnt_r    <= '0;
                    hold_cnt <= HOLD_LOAD;
                    if (HOLD_CYCLES > 0) begin
                        state <= HOLD;
                    end else begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd0) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_r  <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q       = q_r;
    assign bus.gnt     = gnt_r;
    assign bus.owner   = owner_r;
    assign bus.q_valid = q_valid_r;
    assign bus.busy    = busy_r;
endmodule

// File: tb/tb_reg_share_arbiter.sv
// Testbench for reg_share_arbiter (NUM_REQ=4, WIDTH=4, HOLD_CYCLES=2).
module tb_reg_share_arbiter;
    localparam int NR   = 4;
    localparam int W    = 4;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    reg_share_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    reg_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: arbitration is allowed only when no grant happened in
    // the last HOLD+1 edges; winner is the first requester at/after the pointer.
    int          m_ptr;
    int          m_ignore;
    logic [3:0]  m_q;
    logic [1:0]  m_owner;
    logic        m_valid;
    logic [3:0]  m_gnt;
    int          m_cnt;

    task automatic model_edge(input logic r, input logic [3:0] rq, input logic [15:0] wd);
        int w;
        if (r) begin
            m_ptr = 0; m_ignore = 0; m_q = 0; m_owner = 0; m_valid = 0; m_gnt = 0; m_cnt = 0;
        end else if (m_ignore > 0) begin
            m_ignore--;
            m_gnt = 0;
        end else if (rq != 0) begin
            w = -1;
            for (int k = 0; k < NR; k++)
                if (w < 0 && rq[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            m_q      = wd[w*W +: W];
            m_owner  = 2'(w);
            m_valid  = 1;
            m_gnt    = 4'(1 << w);
            m_ptr    = (w + 1) % NR;
            m_ignore = HOLD + 1;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_gnt = 0;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [15:0] wd);
        rst       = r;
        bus.req   = rq;
        bus.wdata = wd;
        @(posedge clk);
        model_edge(r, rq, wd);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(1'b1, 4'($urandom), 16'($urandom));
            vectors++;
            if ({bus.q, bus.q_valid, bus.gnt, bus.owner, bus.busy} !== 12'h000) begin
                miscompares++;
                $display("FAIL reset: q=%0h q_valid=%0b gnt=%0h owner=%0d busy=%0b, required all zero",
                         bus.q, bus.q_valid, bus.gnt, bus.owner, bus.busy);
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] wd;
        logic exp_busy;
        wd = 16'($urandom);
        wd[11:8] = 4'hA;
        step(1'b0, 4'b0100, wd);
        vectors++;
        if (bus.gnt !== 4'b0100 || bus.q !== 4'hA || bus.owner !== 2'd2 || bus.q_valid !== 1'b1 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: gnt=%0h q=%0h owner=%0d q_valid=%0b busy=%0b, required gnt=4 q=a owner=2 q_valid=1 busy=1",
                     bus.gnt, bus.q, bus.owner, bus.q_valid, bus.busy);
        end
        for (int c = 1; c <= 5; c++) begin
            step(1'b0, 4'b0000, wd);
            exp_busy = (c < 3);
            vectors++;
            if (bus.busy !== exp_busy || bus.gnt !== 4'b0000 || bus.q !== 4'hA) begin
                miscompares++;
                $display("FAIL single_after cycle %0d: busy=%0b gnt=%0h q=%0h, required busy=%0b gnt=0 q=a",
                         c, bus.busy, bus.gnt, bus.q, exp_busy);
            end
        end
    endtask

    task automatic test_round_robin();
        int g_idx[$];
        int g_cyc[$];
        logic [3:0] g_q[$];
        int exp_idx[5] = '{0, 1, 2, 3, 0};
        step(1'b1, 4'b0, 16'h0);
        step(1'b1, 4'b0, 16'h0);
        for (int c = 1; c <= 17; c++) begin
            step(1'b0, 4'b1111, 16'h4321);
            if (bus.gnt !== 4'b0000) begin
                g_idx.push_back(int'(bus.owner));
                g_cyc.push_back(c);
                g_q.push_back(bus.q);
                vectors++;
                if (bus.gnt !== 4'(1 << bus.owner)) begin
                    miscompares++;
                    $display("FAIL rr_onehot cycle %0d: gnt=%0h owner=%0d", c, bus.gnt, bus.owner);
                end
            end
        end
        vectors++;
        if (g_idx.size() != 5) begin
            miscompares++;
            $display("FAIL rr_count: grants=%0d, required 5", g_idx.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (g_idx[i] != exp_idx[i] || g_q[i] !== 4'(exp_idx[i] + 1) || g_cyc[i] != 1 + 4*i) begin
                    miscompares++;
                    $display("FAIL rr_grant %0d: owner=%0d q=%0h cycle=%0d, required owner=%0d q=%0h cycle=%0d",
                             i, g_idx[i], g_q[i], g_cyc[i], exp_idx[i], exp_idx[i] + 1, 1 + 4*i);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] wd;
        int got[$];
        logic [3:0] got_q[$];
        logic [3:0] rq;
        wd = 16'($urandom);
        step(1'b1, 4'b0, 16'h0);
        step(1'b0, 4'b0100, wd);          // grant 2 moves the pointer to 3
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0, wd);
        for (int c = 1; c <= 9; c++) begin
            rq = (c <= 5) ? 4'b1001 : ((c == 9) ? 4'b1111 : 4'b0000);
            step(1'b0, rq, wd);
            if (bus.gnt !== 4'b0000) begin
                got.push_back(int'(bus.owner));
                got_q.push_back(bus.q);
            end
        end
        vectors++;
        if (got.size() != 3 || got[0] != 3 || got[1] != 0 || got[2] != 1) begin
            miscompares++;
            $display("FAIL wrap_order: %0d grants %p, required 3,0,1", got.size(), got);
        end else begin
            vectors++;
            if (got_q[0] !== wd[15:12] || got_q[1] !== wd[3:0] || got_q[2] !== wd[7:4]) begin
                miscompares++;
                $display("FAIL wrap_data: q=%0h,%0h,%0h required %0h,%0h,%0h",
                         got_q[0], got_q[1], got_q[2], wd[15:12], wd[3:0], wd[7:4]);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [15:0] wd;
        wd = 16'($urandom) | 16'h0011;
        step(1'b1, 4'b0, 16'h0);
        step(1'b0, 4'b0100, wd);          // GRANT
        step(1'b0, 4'b0000, wd);          // HOLD 1
        step(1'b0, 4'b0000, wd);          // HOLD 2
        step(1'b1, 4'b0011, wd);
        vectors++;
        if (bus.q !== 4'h0 || bus.q_valid !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== 4'b0 || bus.owner !== 2'd0) begin
            miscompares++;
            $display("FAIL mid_hold_reset: q=%0h q_valid=%0b busy=%0b gnt=%0h owner=%0d, required all zero",
                     bus.q, bus.q_valid, bus.busy, bus.gnt, bus.owner);
        end
        step(1'b0, 4'b0011, wd);
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0 || bus.q !== wd[3:0] || bus.q_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_grant: gnt=%0h owner=%0d q=%0h, required gnt=1 owner=0 q=%0h",
                     bus.gnt, bus.owner, bus.q, wd[3:0]);
        end
    endtask

    task automatic test_random();
        logic r;
        logic [3:0] rq;
        step(1'b1, 4'b0, 16'h0);
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(0, 39) == 0);
            rq = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
            step(r, rq, 16'($urandom));
            vectors++;
            if (bus.gnt !== m_gnt || bus.q !== m_q || bus.owner !== m_owner ||
                bus.q_valid !== m_valid || bus.busy !== (m_ignore > 0)) begin
                miscompares++;
                $display("FAIL random cycle %0d: gnt=%0h q=%0h owner=%0d q_valid=%0b busy=%0b, required gnt=%0h q=%0h owner=%0d q_valid=%0b busy=%0b",
                         c, bus.gnt, bus.q, bus.owner, bus.q_valid, bus.busy,
                         m_gnt, m_q, m_owner, m_valid, (m_ignore > 0));
            end
`ifdef REG_ARB_STATS_EN
            vectors++;
            if (bus.grant_cnt !== 16'(m_cnt)) begin
                miscompares++;
                $display("FAIL random_grant_cnt cycle %0d: %0d, required %0d", c, bus.grant_cnt, m_cnt);
            end
`endif
        end
    endtask

`ifdef REG_ARB_STATS_EN
    task automatic test_stats();
        step(1'b1, 4'b0, 16'h0);
        for (int c = 0; c < 20; c++) step(1'b0, 4'b0001, 16'h0005);
        vectors++;
        if (bus.grant_cnt !== 16'd5) begin
            miscompares++;
            $display("FAIL stats_count: %0d, required 5", bus.grant_cnt);
        end
    endtask
`endif

    initial begin
        bus.req   = '0;
        bus.wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid_hold();
        test_random();
`ifdef REG_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
